// File: rtl/sprite_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sprite_plotter                                                           |
// | Erase/draw 8x8 sprites as one clipped pixel per clock to a frame buffer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sprite_plotter #(
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic [8:0] req_x,
  input  logic [7:0] req_y,
  input  logic [1:0] req_sprite,
  input  logic [2:0] req_colour,
  input  logic       req_erase,
  output logic       ready,
  output logic       done,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ERASE = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [9:0] c_SCREEN_W = 10'(SCREEN_W);
  localparam logic [8:0] c_SCREEN_H = 9'(SCREEN_H);

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [5:0] r_k;
  logic [8:0] r_lat_x;
  logic [7:0] r_lat_y;
  logic [1:0] r_lat_sprite;
  logic [2:0] r_lat_colour;
  logic [8:0] r_prev_x;
  logic [7:0] r_prev_y;
  logic       r_prev_valid;
  logic [8:0] r_x;
  logic [7:0] r_y;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_done;

  logic       w_accept;
  logic       w_last;
  logic [8:0] w_base_x;
  logic [7:0] w_base_y;
  logic [9:0] w_px;
  logic [8:0] w_py;
  logic       w_onscreen;
  logic       w_rom_bit;
  logic [8:0] w_x_next;
  logic [7:0] w_y_next;
  logic [2:0] w_colour_next;
  logic       w_plot_next;
  logic       w_done_next;

  // Bit set = foreground pixel at (row r, column c) of sprite s.
  function automatic logic rom_bit(input logic [1:0] s, input logic [2:0] r, input logic [2:0] c);
    case (s)
      2'd0:    rom_bit = 1'b1;
      2'd1:    rom_bit = (r == 3'd3 || r == 3'd4) && (c == 3'd3 || c == 3'd4);
      2'd2:    rom_bit = (r == 3'd0) || (r == 3'd7) || (c == 3'd0) || (c == 3'd7);
      default: rom_bit = 1'b0;
    endcase
  endfunction

  assign w_accept   = req && (r_state == S_IDLE);
  assign w_last     = (r_k == 6'd63);
  assign w_base_x   = (r_state == S_ERASE) ? r_prev_x : r_lat_x;
  assign w_base_y   = (r_state == S_ERASE) ? r_prev_y : r_lat_y;
  assign w_px       = {1'b0, w_base_x} + {7'd0, r_k[2:0]};
  assign w_py       = {1'b0, w_base_y} + {6'd0, r_k[5:3]};
  assign w_onscreen = (w_px < c_SCREEN_W) && (w_py < c_SCREEN_H);
  assign w_rom_bit  = rom_bit(r_lat_sprite, r_k[5:3], r_k[2:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = (req_erase && r_prev_valid) ? S_ERASE : S_DRAW;
      S_ERASE: if (w_last) w_state_next = S_DRAW;
      S_DRAW:  if (w_last) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next registered pixel-port values; clipped/blank pixels keep the last colour.
  always_comb begin
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_colour_next = r_colour;
    w_plot_next   = 1'b0;
    w_done_next   = 1'b0;
    case (r_state)
      S_ERASE: begin
        w_x_next    = w_px[8:0];
        w_y_next    = w_py[7:0];
        w_plot_next = w_onscreen;
        if (w_onscreen) w_colour_next = BG_COLOUR;
      end
      S_DRAW: begin
        w_x_next    = w_px[8:0];
        w_y_next    = w_py[7:0];
        w_plot_next = w_onscreen && w_rom_bit;
        if (w_onscreen && w_rom_bit) w_colour_next = r_lat_colour;
      end
      S_DONE:  w_done_next = 1'b1;
      default: w_done_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k          <= 6'd0;
      r_lat_x      <= 9'd0;
      r_lat_y      <= 8'd0;
      r_lat_sprite <= 2'd0;
      r_lat_colour <= 3'd0;
      r_prev_x     <= 9'd0;
      r_prev_y     <= 8'd0;
      r_prev_valid <= 1'b0;
      r_x          <= 9'd0;
      r_y          <= 8'd0;
      r_colour     <= 3'd0;
      r_plot       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_colour <= w_colour_next;
      r_plot   <= w_plot_next;
      r_done   <= w_done_next;
      if (r_state == S_ERASE || r_state == S_DRAW) begin
        r_k <= r_k + 6'd1;
      end else begin
        r_k <= 6'd0;
      end
      if (w_accept) begin
        r_lat_x      <= req_x;
        r_lat_y      <= req_y;
        r_lat_sprite <= req_sprite;
        r_lat_colour <= req_colour;
      end
      if (r_state == S_DONE) begin
        r_prev_x     <= r_lat_x;
        r_prev_y     <= r_lat_y;
        r_prev_valid <= 1'b1;
      end
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign done   = r_done;
  assign x      = r_x;
  assign y      = r_y;
  assign colour = r_colour;
  assign plot   = r_plot;

endmodule
`default_nettype wire

// File: tb/tb_sprite_plotter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sprite_plotter                                                        |
// | Directed + random requests against a per-request pixel-list model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req = 1'b0;
  logic [8:0] req_x = '0;
  logic [7:0] req_y = '0;
  logic [1:0] req_sprite = '0;
  logic [2:0] req_colour = '0;
  logic       req_erase = 1'b0;
  logic       ready, done, plot;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;

  sprite_plotter dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_sprite(req_sprite), .req_colour(req_colour), .req_erase(req_erase),
    .ready(ready), .done(done), .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [4][8];
  int         m_prev_x, m_prev_y;
  bit         m_prev_valid;
  logic [2:0] m_last_col;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_x"}, 32'(x), 32'd0);
    check({tag, "_y"}, 32'(y), 32'd0);
    check({tag, "_colour"}, 32'(colour), 32'd0);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge.
  task automatic run_req(input int rx, input int ry, input int sp, input int col,
                         input bit er, input bit noise, input int abort_at);
    bit         e_plot [128];
    int         e_x [128];
    int         e_y [128];
    logic [2:0] e_col [128];
    int         n_pix, idx, px, py, bx, by;
    bit         on;
    check("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; req_x = 9'(rx); req_y = 8'(ry);
    req_sprite = 2'(sp); req_colour = 3'(col); req_erase = er;
    idx = 0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0 && !(er && m_prev_valid)) continue;
      bx = (pass == 0) ? m_prev_x : rx;
      by = (pass == 0) ? m_prev_y : ry;
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          px = bx + c;
          py = by + r;
          on = (px < 320) && (py < 240);
          e_x[idx]    = px % 512;
          e_y[idx]    = py % 256;
          e_plot[idx] = (pass == 0) ? on : (on && rom[sp][r][c]);
          e_col[idx]  = (pass == 0) ? 3'b000 : 3'(col);
          idx++;
        end
      end
    end
    n_pix = idx;
    @(posedge clk);
    for (int n = 1; n <= n_pix + 2; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        resetn = 1'b0;
        req = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        m_prev_valid = 1'b0;
        m_prev_x = 0;
        m_prev_y = 0;
        m_last_col = 3'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready), 32'd1);
        return;
      end
      if (n == 1) begin
        check("first_plot", 32'(plot), 32'd0);
        check("first_ready", 32'(ready), 32'd0);
        check("first_done", 32'(done), 32'd0);
      end else if (n <= n_pix + 1) begin
        idx = n - 2;
        if (e_plot[idx]) m_last_col = e_col[idx];
        check("pix_plot", 32'(plot), 32'(e_plot[idx]));
        check("pix_x", 32'(x), 32'(e_x[idx]));
        check("pix_y", 32'(y), 32'(e_y[idx]));
        check("pix_colour", 32'(colour), 32'(m_last_col));
        check("pix_done", 32'(done), 32'd0);
        check("pix_ready", 32'(ready), 32'd0);
      end else begin
        check("done_pulse", 32'(done), 32'd1);
        check("done_plot", 32'(plot), 32'd0);
        check("done_ready", 32'(ready), 32'd1);
        check("done_colour", 32'(colour), 32'(m_last_col));
      end
      if (noise && n < n_pix + 2) begin
        req = 1'b1;
        req_x = 9'($urandom); req_y = 8'($urandom);
        req_sprite = 2'($urandom); req_colour = 3'($urandom);
        req_erase = 1'($urandom);
      end else begin
        req = 1'b0;
      end
    end
    m_prev_x = rx;
    m_prev_y = ry;
    m_prev_valid = 1'b1;
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 8; r++)
        rom[s][r] = 8'h00;
    for (int r = 0; r < 8; r++) begin
      rom[0][r] = 8'hFF;
      rom[2][r] = (r == 0 || r == 7) ? 8'hFF : 8'h81;
    end
    rom[1][3] = 8'h18;
    rom[1][4] = 8'h18;
    m_prev_x = 0; m_prev_y = 0; m_prev_valid = 1'b0; m_last_col = 3'd0;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);
    check("ready_reset", 32'(ready), 32'd1);
    check("plot_idle", 32'(plot), 32'd0);

    run_req(100, 50, 1, 6, 1'b1, 1'b0, 0);
    run_req(110, 50, 0, 4, 1'b1, 1'b0, 0);
    run_req(316, 236, 0, 5, 1'b0, 1'b0, 0);
    run_req(0, 0, 2, 7, 1'b1, 1'b0, 0);
    run_req(20, 30, 0, 3, 1'b0, 1'b0, 40);
    run_req(40, 40, 1, 2, 1'b1, 1'b0, 0);
    run_req(60, 60, 2, 5, 1'b1, 1'b1, 0);
    for (int i = 0; i < 10; i++) begin
      run_req($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 3),
              $urandom_range(0, 7), 1'($urandom), 1'($urandom), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
